// File: rtl/seq_detect_scheduler_if.sv
// Request/response bus of seq_detect_scheduler.
// master: the requesters and the result consumer. slave: the scheduler.
// With SEQDET_MATCH_MASK_EN defined the response also carries rsp_mask.
// NUM_REQ and DATA_W must match the parameters of the scheduler it connects to.
interface seq_detect_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [CNT_W-1:0]          rsp_count;
    logic                      rsp_ready;
`ifdef SEQDET_MATCH_MASK_EN
    logic [DATA_W-1:0]         rsp_mask;

    modport master (output req_valid, req_data, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_mask);
    modport slave  (input  req_valid, req_data, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_count, rsp_mask);
`else
    modport master (output req_valid, req_data, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_count);
    modport slave  (input  req_valid, req_data, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_count);
`endif
endinterface

// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: one overlapping Mealy pattern detector shared
// round-robin between NUM_REQ word requesters. A granted word is shifted
// MSB-first, one bit per cycle, and its match count is returned tagged with
// the requester ID. Optional feature macro: SEQDET_MATCH_MASK_EN (adds a
// per-bit match mask to the response).
module seq_detect_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int PAT_W   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    seq_detect_scheduler_if.slave        bus,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    output logic                         busy,
    output logic                         det_pulse
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int LEN_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     ptr_r;
    logic [PAT_W-1:0]    pattern_r;
    logic [LEN_W-1:0]    len_r;
    logic [PAT_W-1:0]    hist_r;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [DATA_W-1:0]   word_r;
    logic [ID_W-1:0]     id_r;
    logic                busy_r;
    logic                det_pulse_r;
    logic                rsp_valid_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic [CNT_W-1:0]    rsp_count_r;

    logic                grant_found_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic [NUM_REQ-1:0]  req_ready_s;
    logic [PAT_W-1:0]    len_mask_s;
    logic [PAT_W-1:0]    hist_next_s;
    logic [CNT_W-1:0]    shifted_s;
    logic [CNT_W-1:0]    count_next_s;
    logic                match_s;

`ifdef SEQDET_MATCH_MASK_EN
    logic [DATA_W-1:0]   mask_acc_r;
    logic [DATA_W-1:0]   rsp_mask_r;
    logic [DATA_W-1:0]   mask_next_s;

    // Working mask with the bit currently being shifted marked on a match.
    always_comb begin
        mask_next_s = mask_acc_r;
        mask_next_s[DATA_W-1-int'(bit_cnt_r)] = match_s;
    end

    assign bus.rsp_mask = rsp_mask_r;
`else
    // Match mask not built: the response carries only ID and count.
`endif

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {ID_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found_s && bus.req_valid[(int'(ptr_r) + k) % NUM_REQ]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = ID_W'((int'(ptr_r) + k) % NUM_REQ);
            end else begin
            end
        end
    end

    // Accept pulse in the IDLE cycle the word is latched; cfg_load takes priority.
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        if (!reset && (state_r == IDLE) && !cfg_load && grant_found_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
        end
    end

    // Detector datapath: next history, active-length mask and match decision.
    always_comb begin
        for (int i = 0; i < PAT_W; i++) begin
            len_mask_s[i] = (i < int'(len_r));
        end
        hist_next_s  = PAT_W'({hist_r, word_r[DATA_W-1]});
        shifted_s    = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        match_s      = (state_r == SHIFT) && (len_r != {LEN_W{1'b0}}) &&
                       (int'(shifted_s) >= int'(len_r)) &&
                       (((hist_next_s ^ pattern_r) & len_mask_s) == {PAT_W{1'b0}});
        count_next_s = count_r + {{(CNT_W-1){1'b0}}, match_s};
    end

    // Control FSM with registered outputs: IDLE -> SHIFT (DATA_W cycles) -> RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= {ID_W{1'b0}};
            pattern_r   <= {PAT_W{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            hist_r      <= {PAT_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
            word_r      <= {DATA_W{1'b0}};
            id_r        <= {ID_W{1'b0}};
            busy_r      <= 1'b0;
            det_pulse_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_count_r <= {CNT_W{1'b0}};
`ifdef SEQDET_MATCH_MASK_EN
            mask_acc_r  <= {DATA_W{1'b0}};
            rsp_mask_r  <= {DATA_W{1'b0}};
`endif
        end else begin
            det_pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cfg_load) begin
                        pattern_r <= cfg_pattern;
                        len_r     <= (int'(cfg_len) > PAT_W) ? LEN_W'(PAT_W) : cfg_len;
                    end else if (grant_found_s) begin
                        word_r    <= bus.req_data[int'(grant_idx_s)*DATA_W +: DATA_W];
                        id_r      <= grant_idx_s;
                        ptr_r     <= ID_W'((int'(grant_idx_s) + 1) % NUM_REQ);
                        hist_r    <= {PAT_W{1'b0}};
                        count_r   <= {CNT_W{1'b0}};
                        bit_cnt_r <= {CNT_W{1'b0}};
`ifdef SEQDET_MATCH_MASK_EN
                        mask_acc_r <= {DATA_W{1'b0}};
`endif
                        busy_r    <= 1'b1;
                        state_r   <= SHIFT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SHIFT: begin
                    word_r      <= {word_r[DATA_W-2:0], 1'b0};
                    hist_r      <= hist_next_s;
                    count_r     <= count_next_s;
                    det_pulse_r <= match_s;
`ifdef SEQDET_MATCH_MASK_EN
                    mask_acc_r  <= mask_next_s;
`endif
                    if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_r   <= {CNT_W{1'b0}};
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_count_r <= count_next_s;
`ifdef SEQDET_MATCH_MASK_EN
                        rsp_mask_r  <= mask_next_s;
`endif
                        state_r     <= RESP;
                    end else begin
                        bit_cnt_r   <= shifted_s;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_count = rsp_count_r;
    assign busy          = busy_r;
    assign det_pulse     = det_pulse_r;

endmodule
